// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// instruction field positions and the default halt word.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  // Instruction byte layout: aux[7:5] rs[4] rt[3] opcode[2:0]
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned RT_BIT  = 3;
  localparam int unsigned RS_BIT  = 4;
  localparam int unsigned AUX_LSB = 5;
  localparam int unsigned AUX_W   = 3;

  localparam logic [7:0] HALT_WORD_DEFAULT = 8'hFF;

endpackage

// File: rtl/fetch_perf_counter.sv
// 16-bit saturating event counter with enable and synchronous clear.
module fetch_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] count
);

  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else if (clr) begin
      count_q <= 16'h0000;
    end else if (en && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'h0001;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC and fetch controller between the instruction ROM and decode.
// Define FETCH_PERF_EN to build the accepted-transfer counter on fetch_count.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [7:0] HALT_WORD = HALT_WORD_DEFAULT,
  parameter logic [7:0] RESET_PC  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  start_addr,
  output logic [7:0]  imem_addr,
  input  logic [7:0]  imem_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_inst,
  output logic [7:0]  out_pc,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_addr,
  output logic        running,
  output logic        halted,
  output logic [15:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic         out_valid_q, out_valid_d;
  logic [7:0]   out_inst_q, out_inst_d;
  logic [7:0]   out_pc_q, out_pc_d;
  logic         running_q, halted_q;
  logic         fetch_en;
  logic         start_ok;

  assign fetch_en = !out_valid_q || out_ready;
  assign start_ok = start && (state_q != StRun);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          pc_d        = start_addr;
          out_valid_d = 1'b0;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (redirect_valid) begin
          // Flush: drop any unaccepted instruction and skip this cycle's fetch
          pc_d        = redirect_addr;
          out_valid_d = 1'b0;
        end else if (fetch_en) begin
          out_inst_d  = imem_inst;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + 8'd1;
          if (imem_inst == HALT_WORD) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        if (start_ok) begin
          pc_d        = start_addr;
          out_valid_d = 1'b0;
          state_d     = StRun;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q  <= 8'h00;
      out_pc_q    <= 8'h00;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      running_q   <= (state_d == StRun);
      halted_q    <= (state_d == StHalted);
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign running   = running_q;
  assign halted    = halted_q;

`ifdef FETCH_PERF_EN
  fetch_perf_counter u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (out_valid_q && out_ready),
    .clr   (start_ok),
    .count (fetch_count)
  );
`else
  assign fetch_count = 16'h0000;
`endif

endmodule
